mul_float_norm: RTL

- Downstream stage of the 2-latency float32 multiplier core. Consumes the raw sign, biased 10-bit exponent, 48-bit significand product and operand exception flags; produces a packed IEEE-754 single-precision result.
- Normalises, rounds to nearest-even and handles special values. Flushes to zero (no denormals).
- 2-cycle latency. Uses the same valid/busy register-stage handshake as the core so the two stages chain directly.

---
 rtl/mul_float_pkg.sv | 52 +++++
 rtl/mul_float_norm_stage.sv | 48 ++++
 rtl/mul_float_norm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mul_float_pkg.sv
// Shared types and constants for the float32 multiplier normalise/round stage.
package mul_float_pkg;

    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_ZERO = 2'd1,
        SPC_INF  = 2'd2,
        SPC_NAN  = 2'd3
    } special_e;

    localparam int unsigned     EXP_BIAS = 127;
    localparam logic [9:0]      EXP_MAX  = 10'd255;
    localparam logic [31:0]     QNAN     = 32'h7FC0_0000;

    typedef struct packed {
        logic       sign;
        logic [9:0] exp;
        logic [22:0] mant;
        logic       guard;
        logic       sticky;
        special_e   special;
    } s0_payload_t;

    typedef struct packed {
        logic [31:0] result;
        logic        invalid;
        logic        overflow;
        logic        underflow;
        logic        inexact;
    } s1_payload_t;

    // Infinity times zero is invalid; otherwise infinity dominates zero.
    function automatic special_e decode_special(
        input logic a0,
        input logic b0,
        input logic a1,
        input logic b1
    );
        special_e code;
        if ((a1 | b1) & (a0 | b0)) begin
            code = SPC_NAN;
        end else if (a1 | b1) begin
            code = SPC_INF;
        end else if (a0 | b0) begin
            code = SPC_ZERO;
        end else begin
            code = SPC_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/mul_float_norm_stage.sv
// Generic valid/busy register stage: loads when downstream is not busy, holds otherwise.
module mul_float_norm_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         in_valid,
    input  logic         in_busy,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    // Next-state: synchronous clear, load when free, hold under stall.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (srst) begin
            valid_d = 1'b0;
            data_d  = {W{1'b0}};
        end else if (!in_busy) begin
            valid_d = in_valid;
            data_d  = in_data;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/mul_float_norm.sv
// Float32 multiplier back end: normalise the 48-bit product, round to nearest-even,
// resolve special values and pack the IEEE-754 result over two register stages.
module mul_float_norm
    import mul_float_pkg::*;
#(
    parameter logic [31:0] P_QNAN = QNAN
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iDATA_REQ,
    output logic        oDATA_BUSY,
    input  logic        iDATA_SIGN,
    input  logic [9:0]  iDATA_EXP,
    input  logic [47:0] iDATA_FRACT,
    input  logic        iDATA_EXCEPT_EXP_A0,
    input  logic        iDATA_EXCEPT_EXP_B0,
    input  logic        iDATA_EXCEPT_EXP_A1,
    input  logic        iDATA_EXCEPT_EXP_B1,
    input  logic        iDATA_EXCEPT_FRACT_A0,
    input  logic        iDATA_EXCEPT_FRACT_B0,
    output logic        oDATA_VALID,
    input  logic        iDATA_BUSY,
    output logic [31:0] oDATA_RESULT,
    output logic        oDATA_INVALID,
    output logic        oDATA_OVERFLOW,
    output logic        oDATA_UNDERFLOW,
    output logic        oDATA_INEXACT
);

    s0_payload_t s0_d, s0_q;
    s1_payload_t s1_d, s1_q;
    logic        s0_valid_q;
    logic        s1_valid_q;
    logic        s0_load_s;
    logic [23:0] rnd_sum_s;
    logic        rnd_up_s;
    logic [9:0]  exp_rnd_s;
    logic        unused_s;

    // Fraction-zero exception inputs are reserved for future denormal support.
    assign unused_s   = iDATA_EXCEPT_FRACT_A0 ^ iDATA_EXCEPT_FRACT_B0;

    assign oDATA_BUSY = iDATA_BUSY;
    assign s0_load_s  = iDATA_REQ & ~iDATA_BUSY;

    // Normalise: product lies in [1,4); a set MSB means shift right by one and bump the exponent.
    always_comb begin
        s0_d.sign    = iDATA_SIGN;
        s0_d.special = decode_special(iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0,
                                      iDATA_EXCEPT_EXP_A1, iDATA_EXCEPT_EXP_B1);
        if (iDATA_FRACT[47]) begin
            s0_d.mant   = iDATA_FRACT[46:24];
            s0_d.guard  = iDATA_FRACT[23];
            s0_d.sticky = |iDATA_FRACT[22:0];
            s0_d.exp    = iDATA_EXP + 10'd1;
        end else begin
            s0_d.mant   = iDATA_FRACT[45:23];
            s0_d.guard  = iDATA_FRACT[22];
            s0_d.sticky = |iDATA_FRACT[21:0];
            s0_d.exp    = iDATA_EXP;
        end
    end

    mul_float_norm_stage #(
        .W($bits(s0_payload_t))
    ) u_stage0 (
        .clk       (iCLOCK),
        .rst_n     (inRESET),
        .srst      (iRESET_SYNC),
        .in_valid  (s0_load_s),
        .in_busy   (iDATA_BUSY),
        .in_data   (s0_d),
        .out_valid (s0_valid_q),
        .out_data  (s0_q)
    );

    // Round to nearest-even; a mantissa carry leaves Mr at zero and bumps the exponent.
    always_comb begin
        rnd_up_s  = s0_q.guard & (s0_q.sticky | s0_q.mant[0]);
        rnd_sum_s = {1'b0, s0_q.mant} + {23'd0, rnd_up_s};
        exp_rnd_s = s0_q.exp + {9'd0, rnd_sum_s[23]};
    end

    // Result selection in priority order: NaN, Inf, zero, overflow, underflow, normal.
    always_comb begin
        s1_d = '{result: 32'd0, invalid: 1'b0, overflow: 1'b0,
                 underflow: 1'b0, inexact: 1'b0};
        case (s0_q.special)
            SPC_NAN: begin
                s1_d.result  = P_QNAN;
                s1_d.invalid = 1'b1;
            end
            SPC_INF: begin
                s1_d.result = {s0_q.sign, 8'hFF, 23'd0};
            end
            SPC_ZERO: begin
                s1_d.result = {s0_q.sign, 31'd0};
            end
            SPC_NONE: begin
                if ($signed(exp_rnd_s) >= $signed(EXP_MAX)) begin
                    s1_d.result   = {s0_q.sign, 8'hFF, 23'd0};
                    s1_d.overflow = 1'b1;
                    s1_d.inexact  = 1'b1;
                end else if ($signed(exp_rnd_s) <= $signed(10'd0)) begin
                    s1_d.result    = {s0_q.sign, 31'd0};
                    s1_d.underflow = 1'b1;
                    s1_d.inexact   = 1'b1;
                end else begin
                    s1_d.result  = {s0_q.sign, exp_rnd_s[7:0], rnd_sum_s[22:0]};
                    s1_d.inexact = s0_q.guard | s0_q.sticky;
                end
            end
            default: begin
                s1_d.result  = P_QNAN;
                s1_d.invalid = 1'b1;
            end
        endcase
    end

    mul_float_norm_stage #(
        .W($bits(s1_payload_t))
    ) u_stage1 (
        .clk       (iCLOCK),
        .rst_n     (inRESET),
        .srst      (iRESET_SYNC),
        .in_valid  (s0_valid_q),
        .in_busy   (iDATA_BUSY),
        .in_data   (s1_d),
        .out_valid (s1_valid_q),
        .out_data  (s1_q)
    );

    assign oDATA_VALID     = s1_valid_q;
    assign oDATA_RESULT    = s1_q.result;
    assign oDATA_INVALID   = s1_q.invalid;
    assign oDATA_OVERFLOW  = s1_q.overflow;
    assign oDATA_UNDERFLOW = s1_q.underflow;
    assign oDATA_INEXACT   = s1_q.inexact;

endmodule
